// File: rtl/arb_requester.sv
// ---------------------------------------------------------------------------
// arb_requester
// Initiator-side engine for one port of the three-port round-robin
// shared-memory arbiter. Takes single read/write commands from local logic,
// runs the four-phase req/ack handshake toward the arbiter, and returns a
// one-cycle completion pulse with status and read data.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   cmd_valid    command present
//   cmd_ready    command accepted when cmd_valid & cmd_ready at a rising edge
//   cmd_rdWrn    1 = read, 0 = write
//   cmd_address  command address
//   cmd_wrdata   write data
//   rsp_valid    one-cycle completion pulse
//   rsp_status   00 ok, 01 grant timeout, 10 grant revoked
//   rsp_rddata   read data; 0 for writes and errors
//   req          request to arbiter
//   ack          grant from arbiter
//   address      address to arbiter port
//   wrdata       write data to arbiter port
//   rdWrn        read/write select to arbiter port
//   rddata       read data from arbiter port
// ---------------------------------------------------------------------------
module arb_requester #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT_WIDTH = 6,
  parameter int RD_LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rdWrn,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_wrdata,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [DATA_WIDTH-1:0] rsp_rddata,
  output logic                  req,
  input  logic                  ack,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic                  rdWrn,
  input  logic [DATA_WIDTH-1:0] rddata
);

  localparam int BEAT_WIDTH = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(RD_LATENCY - 1);

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_REVOKED = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    RELEASE
  } state_t;

  state_t                   stateReg, stateNext;
  logic [TIMEOUT_WIDTH-1:0] waitCntReg, waitCntNext;
  logic [BEAT_WIDTH-1:0]    beatCntReg, beatCntNext;
  logic                     reqReg, reqNext;
  logic                     rspValidReg, rspValidNext;
  logic [1:0]               rspStatusReg, rspStatusNext;
  logic [DATA_WIDTH-1:0]    rspRddataReg, rspRddataNext;
  logic [ADDR_WIDTH-1:0]    addressReg, addressNext;
  logic [DATA_WIDTH-1:0]    wrdataReg, wrdataNext;
  logic                     rdWrnReg, rdWrnNext;

  // A stale grant from the previous transaction must be seen low before a
  // new request may start, so ack gates acceptance combinationally.
  assign cmd_ready = (stateReg == IDLE) && !ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg     <= IDLE;
      waitCntReg   <= '0;
      beatCntReg   <= '0;
      reqReg       <= 1'b0;
      rspValidReg  <= 1'b0;
      rspStatusReg <= STATUS_OK;
      rspRddataReg <= '0;
      addressReg   <= '0;
      wrdataReg    <= '0;
      rdWrnReg     <= 1'b1;
    end else begin
      stateReg     <= stateNext;
      waitCntReg   <= waitCntNext;
      beatCntReg   <= beatCntNext;
      reqReg       <= reqNext;
      rspValidReg  <= rspValidNext;
      rspStatusReg <= rspStatusNext;
      rspRddataReg <= rspRddataNext;
      addressReg   <= addressNext;
      wrdataReg    <= wrdataNext;
      rdWrnReg     <= rdWrnNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    waitCntNext   = waitCntReg;
    beatCntNext   = beatCntReg;
    reqNext       = reqReg;
    rspValidNext  = 1'b0;           // completion is a single-cycle pulse
    rspStatusNext = rspStatusReg;
    rspRddataNext = rspRddataReg;
    addressNext   = addressReg;
    wrdataNext    = wrdataReg;
    rdWrnNext     = rdWrnReg;

    unique case (stateReg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addressNext = cmd_address;
          wrdataNext  = cmd_wrdata;
          rdWrnNext   = cmd_rdWrn;
          reqNext     = 1'b1;
          waitCntNext = '0;
          stateNext   = REQ;
        end
      end

      REQ: begin
        // A grant on the same edge the counter expires still wins.
        if (ack) begin
          beatCntNext = '0;
          stateNext   = ACCESS;
        end else if (waitCntReg == '1) begin
          reqNext       = 1'b0;
          rspValidNext  = 1'b1;
          rspStatusNext = STATUS_TIMEOUT;
          rspRddataNext = '0;
          stateNext     = RELEASE;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
        end
      end

      ACCESS: begin
        if (!ack) begin
          // Grant withdrawn before the data edge: ack is already low, so
          // there is no close-out phase to wait for.
          reqNext       = 1'b0;
          rspValidNext  = 1'b1;
          rspStatusNext = STATUS_REVOKED;
          rspRddataNext = '0;
          stateNext     = IDLE;
        end else if (beatCntReg == LAST_BEAT) begin
          reqNext       = 1'b0;
          rspValidNext  = 1'b1;
          rspStatusNext = STATUS_OK;
          rspRddataNext = rdWrnReg ? rddata : '0;
          stateNext     = RELEASE;
        end else begin
          beatCntNext = beatCntReg + 1'b1;
        end
      end

      RELEASE: begin
        if (!ack) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign req        = reqReg;
  assign rsp_valid  = rspValidReg;
  assign rsp_status = rspStatusReg;
  assign rsp_rddata = rspRddataReg;
  assign address    = addressReg;
  assign wrdata     = wrdataReg;
  assign rdWrn      = rdWrnReg;

endmodule
